// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - FIFO-buffered LSB-first word serialiser feeding a 1-to-4 bit demux
module demux_route_ctrl #(
    parameter int W     = 8,    // data bits per word (>=2)
    parameter int DEPTH = 4,    // FIFO entries (power of 2, >=2)
    parameter int GAP   = 1     // idle cycles between frames
) (
    input  logic                         clk,          // rising-edge clock
    input  logic                         rst,          // synchronous, active-high
    input  logic                         in_valid,     // word offered
    output logic                         in_ready,     // FIFO not full
    input  logic [W-1:0]                 in_data,      // word to serialise
    input  logic [1:0]                   in_dest,      // {s1,s0} for this word
    input  logic                         hold,         // freeze FSM, counters, outputs
    output logic                         s1,           // demux select MSB
    output logic                         s0,           // demux select LSB
    output logic                         I,            // serial data bit
    output logic                         frame_start,  // first bit of frame on I
    output logic                         frame_last,   // last bit of frame on I
    output logic                         busy,         // a frame bit is on I
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count    // entries buffered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // FIFO storage: {dest, data}
    logic [W+1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [W-1:0]  head_data;
    logic [1:0]    head_dest;

    state_t        state, state_n;
    logic [W-1:0]  shreg, shreg_n;
    logic [BW-1:0] bitcnt, bitcnt_n;
    logic [BW-1:0] bitcnt_inc;
    logic [GW-1:0] gapcnt, gapcnt_n;
    logic [1:0]    sel_n;
    logic          i_n;
    logic          fs_n;
    logic          fl_n;
    logic          busy_n;
    logic          load;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign fifo_count = count;
    assign head_data  = mem[rd_ptr][W-1:0];
    assign head_dest  = mem[rd_ptr][W+1:W];
    assign bitcnt_inc = bitcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {in_dest, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            gapcnt      <= '0;
            s1          <= 1'b0;
            s0          <= 1'b0;
            I           <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bitcnt      <= bitcnt_n;
            gapcnt      <= gapcnt_n;
            {s1, s0}    <= sel_n;
            I           <= i_n;
            frame_start <= fs_n;
            frame_last  <= fl_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        gapcnt_n = gapcnt;
        sel_n    = {s1, s0};
        i_n      = I;
        fs_n     = frame_start;
        fl_n     = frame_last;
        busy_n   = busy;
        load     = 1'b0;
        pop      = 1'b0;

        if (!hold) begin
            case (state)
                ST_IDLE: begin
                    load = !empty;
                end
                ST_SHIFT: begin
                    if (bitcnt == BIT_LAST) begin
                        fs_n   = 1'b0;
                        fl_n   = 1'b0;
                        i_n    = 1'b0;
                        busy_n = 1'b0;
                        if (GAP > 0) begin
                            state_n  = ST_GAP;
                            gapcnt_n = '0;
                        end else if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        // shreg[0] is the bit currently on I
                        shreg_n  = shreg >> 1;
                        i_n      = shreg[1];
                        bitcnt_n = bitcnt_inc;
                        fs_n     = 1'b0;
                        fl_n     = (bitcnt_inc == BIT_LAST);
                    end
                end
                ST_GAP: begin
                    if (gapcnt == GAP_LAST) begin
                        state_n = ST_IDLE;
                        load    = !empty;
                    end else begin
                        gapcnt_n = gapcnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            if (load) begin
                pop      = 1'b1;
                state_n  = ST_SHIFT;
                shreg_n  = head_data;
                i_n      = head_data[0];
                sel_n    = head_dest;
                bitcnt_n = '0;
                fs_n     = 1'b1;
                fl_n     = 1'b0;
                busy_n   = 1'b1;
            end
        end
    end

endmodule
